// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship cursor/board logic.
package battleship_pkg;

    localparam int COORD_W        = 4;
    localparam int GRID_W_DEFAULT = 10;
    localparam int GRID_H_DEFAULT = 10;

    // Button vector index of the fire button; directions use their enum value.
    localparam int BTN_FIRE = 4;
    localparam int NUM_BTN  = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Level-to-rising-edge converter with a registered pulse output.
// The previous-level register resets to RESET_VAL so that a level already
// high coming out of reset is not mistaken for a fresh press.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Track the previous level and register the rising-edge strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= RESET_VAL;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/grid_cursor.sv
// Board cursor controller: turns debounced button levels into single-step
// cursor moves with hold-to-repeat, edge wrap-around and one-shot fire.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a fresh direction press (up > down > left > right)
// ST_HOLD   | latched direction held, waiting out the initial hold delay
// ST_REPEAT | latched direction still held, stepping every repeat period
module grid_cursor
    import battleship_pkg::*;
#(
    parameter int GRID_W        = GRID_W_DEFAULT,
    parameter int GRID_H        = GRID_H_DEFAULT,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_fire,
    output logic [COORD_W-1:0] cursor_x,
    output logic [COORD_W-1:0] cursor_y,
    output logic               move_pulse,
    output logic               fire_pulse,
    output logic [COORD_W-1:0] fire_x,
    output logic [COORD_W-1:0] fire_y
);

    localparam int CNT_SPAN = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W    = $clog2(CNT_SPAN);

    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [COORD_W-1:0] X_LAST      = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST      = COORD_W'(GRID_H - 1);

    logic [NUM_BTN-1:0] btn_vec;
    logic [NUM_BTN-1:0] rise;

    state_t             state;
    dir_t               dir;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;

    dir_t               new_dir;
    logic               new_press;
    dir_t               mv_dir;
    logic               held;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    assign btn_vec = {btn_fire, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_edge
        rise_detect #(
            .RESET_VAL (1'b1)
        ) u_rise (
            .clk   (clk),
            .reset (reset),
            .level (btn_vec[i]),
            .rise  (rise[i])
        );
    end

    // Pick the winning direction among simultaneous presses.
    always_comb begin
        new_dir   = DIR_UP;
        new_press = 1'b1;
        if (rise[DIR_UP]) begin
            new_dir = DIR_UP;
        end else if (rise[DIR_DOWN]) begin
            new_dir = DIR_DOWN;
        end else if (rise[DIR_LEFT]) begin
            new_dir = DIR_LEFT;
        end else if (rise[DIR_RIGHT]) begin
            new_dir = DIR_RIGHT;
        end else begin
            new_press = 1'b0;
        end
    end

    // Compute the wrapped cursor position one step in the active direction.
    always_comb begin
        mv_dir = (state == ST_IDLE) ? new_dir : dir;
        next_x = cursor_x;
        next_y = cursor_y;
        case (mv_dir)
            DIR_UP:    next_y = (cursor_y == '0)     ? Y_LAST : cursor_y - 1'b1;
            DIR_DOWN:  next_y = (cursor_y == Y_LAST) ? '0     : cursor_y + 1'b1;
            DIR_LEFT:  next_x = (cursor_x == '0)     ? X_LAST : cursor_x - 1'b1;
            DIR_RIGHT: next_x = (cursor_x == X_LAST) ? '0     : cursor_x + 1'b1;
            default:   ;
        endcase
    end

    // The hold check looks at the live level so a release ends repeat at once.
    assign held    = btn_vec[dir];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // Direction FSM, hold/repeat timer, cursor and fire registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            dir        <= DIR_UP;
            cnt        <= '0;
            cursor_x   <= '0;
            cursor_y   <= '0;
            move_pulse <= 1'b0;
            fire_pulse <= 1'b0;
            fire_x     <= '0;
            fire_y     <= '0;
        end else begin
            move_pulse <= 1'b0;
            fire_pulse <= 1'b0;
            if (!enable) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                if (rise[BTN_FIRE]) begin
                    fire_pulse <= 1'b1;
                    fire_x     <= cursor_x;
                    fire_y     <= cursor_y;
                end
                case (state)
                    ST_IDLE: begin
                        if (new_press) begin
                            dir        <= new_dir;
                            cursor_x   <= next_x;
                            cursor_y   <= next_y;
                            move_pulse <= 1'b1;
                            state      <= ST_HOLD;
                            cnt        <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!held) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == HOLD_LAST) begin
                            cursor_x   <= next_x;
                            cursor_y   <= next_y;
                            move_pulse <= 1'b1;
                            state      <= ST_REPEAT;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_REPEAT: begin
                        if (!held) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt == REPEAT_LAST) begin
                            cursor_x   <= next_x;
                            cursor_y   <= next_y;
                            move_pulse <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/grid_cursor.md
# grid_cursor

Consumes the debounced push-button levels (four directions plus fire) and turns them into board-cursor motion and one-shot fire commands for the Battleship game logic. Sits directly downstream of the per-button debouncers and upstream of the board/shot-tracking logic. Each press produces exactly one move. A held direction auto-repeats after a hold delay. Coordinates wrap around at the board edges.

## Interface
- GRID_W, 10, board width in cells (2..16)
- GRID_H, 10, board height in cells (2..16)
- HOLD_CYCLES, 50_000_000, cycles a direction must stay held before auto-repeat starts (>=2)
- REPEAT_CYCLES, 10_000_000, cycles between auto-repeat moves (>=1)
- clk  input  1  system clock; the only clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  high while the game is accepting cursor input
- btn_up, btn_down, btn_left, btn_right  input  1 each  debounced direction levels
- btn_fire  input  1  debounced fire level
- cursor_x  output  4  current column, 0..GRID_W-1
- cursor_y  output  4  current row, 0..GRID_H-1
- move_pulse  output  1  one-cycle strobe, high in the first cycle a new cursor value is visible
- fire_pulse  output  1  one-cycle fire strobe
- fire_x, fire_y  output  4 each  coordinates latched with fire_pulse; held until the next fire

## Operation
- Rising-edge detection on all five buttons uses previous-level registers. The previous-level registers reset to all ones, so a button held through reset is ignored until it is released and pressed again.
- Direction FSM states:
  - IDLE: a rising edge on any direction latches that direction, applies one move, and goes to HOLD with the counter at 0.
  - HOLD: counts while the latched button stays high. When the counter reaches HOLD_CYCLES-1, one move is applied, the FSM goes to REPEAT and the counter clears.
  - REPEAT: counts; when the counter reaches REPEAT_CYCLES-1, one move is applied and the counter clears.
  - In HOLD or REPEAT, releasing the latched button returns the FSM to IDLE on the next edge with no move.
  - In HOLD or REPEAT, presses of other directions are ignored. A new direction is accepted only on a fresh rising edge while in IDLE.
- Simultaneous rising edges: priority is up > down > left > right. Only the winner moves and is latched.
- Move arithmetic and wrap:
  - up: y-1; y=0 wraps to GRID_H-1.
  - down: y+1; GRID_H-1 wraps to 0.
  - left: x-1; x=0 wraps to GRID_W-1.
  - right: x+1; GRID_W-1 wraps to 0.
- Fire: a rising edge of btn_fire produces one fire_pulse and latches fire_x/fire_y from the pre-move cursor value of the same cycle. A move in the same cycle still occurs. Fire never repeats.
- enable low:
  - FSM is forced to IDLE; no moves and no fire.
  - Edge registers keep tracking, so a button already high when enable rises does not act until it is re-pressed.
- Counter width is $clog2 of the larger of HOLD_CYCLES and REPEAT_CYCLES. The counter saturates, never wraps.

## Timing
- All outputs are registered.
- A button sampled high (previously low) at edge N produces the new cursor and move_pulse=1 after edge N+1, for exactly one cycle. fire_pulse follows the same timing.
- Held button, first press at edge N:
  - first move visible after N+1;
  - second move after N+1+HOLD_CYCLES;
  - subsequent moves every REPEAT_CYCLES cycles.
- Reset (synchronous, at any time, including mid-HOLD/REPEAT):
  - cursor_x = cursor_y = 0, fire_x = fire_y = 0;
  - move_pulse = fire_pulse = 0;
  - FSM in IDLE, counter 0, previous-level registers all 1.
- Throughput: at most one move per cycle. Pulses are never stretched.

## Structure
- Shared package battleship_pkg holds:
  - COORD_W = 4;
  - default GRID_W/GRID_H;
  - the direction enum (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT);
  - the FSM state enum (ST_IDLE, ST_HOLD, ST_REPEAT).
- One sub-module, rise_detect: previous-level register with parameterised reset value, emitting a level-to-rising-edge pulse. It is instantiated five times.
- FSM, counter, and coordinate update stay in grid_cursor.

## Test plan
All scenarios run with HOLD_CYCLES=4 and REPEAT_CYCLES=2.
- Reset, pulse btn_right for 1 cycle -> cursor (1,0), move_pulse high for exactly 1 cycle, 2 edges after the sample edge.
- From (0,0) press left, then up -> (9,0), then (9,9); from (9,9) press right, then down -> (0,9), then (0,0).
- Hold btn_down for 12 cycles from (0,0) -> moves after cycles 1, 5, 7, 9, 11 (y=5); release -> no further moves; FSM back in IDLE.
- Rising edges on btn_up and btn_left in the same cycle at (3,3) -> (3,2) only. With up still held, press right -> ignored.
- btn_fire and btn_right rise together at (2,4) -> fire_pulse with fire_x=2, fire_y=4, and cursor (3,4). Holding fire 20 cycles -> one fire_pulse only.
- Two cases with a held button:
  - reset asserted mid-REPEAT with btn_left still high -> cursor (0,0), no move after reset until btn_left is released and re-pressed;
  - enable low during a press -> no move or fire.
